// File: rtl/axil_pkg.sv
// Shared types and helpers for the AXI4-Lite to adder register-file bridge.
// Holds the response codes, the bridge state encoding and the access legality check.
package axil_pkg;

  localparam int AXIL_DATA_W   = 32;
  localparam int AXIL_ADDR_W   = 32;
  localparam int AXIL_STRB_W   = AXIL_DATA_W / 8;
  localparam int AXIL_NUM_REGS = 3;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_EXEC  = 3'd1,
    ST_WR_RESP  = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_RD_RESP  = 3'd5
  } bridge_state_t;

  // An access is legal when it is word aligned, hits an implemented word
  // and, for writes, updates the whole word (no partial-word writes exist).
  function automatic logic addr_legal(
    input logic [AXIL_ADDR_W-1:0] addr,
    input logic [AXIL_STRB_W-1:0] strb,
    input logic                   is_wr
  );
    logic idx_ok;
    logic align_ok;
    logic strb_ok;
    idx_ok   = ({2'b00, addr[AXIL_ADDR_W-1:2]} < AXIL_ADDR_W'(AXIL_NUM_REGS));
    align_ok = (addr[1:0] == 2'b00);
    strb_ok  = (!is_wr) || (strb == {AXIL_STRB_W{1'b1}});
    return idx_ok && align_ok && strb_ok;
  endfunction

endpackage

// File: rtl/axil_regfile_master.sv
// AXI4-Lite slave front-end that turns AW/W/B writes and AR/R reads into
// single-cycle strobes on the 3-word adder register file. One transaction
// is in flight at a time; write and read contend fairly in IDLE.
module axil_regfile_master
  import axil_pkg::*;
#(
  parameter int DATA_W   = AXIL_DATA_W,
  parameter int ADDR_W   = AXIL_ADDR_W,
  parameter int NUM_REGS = AXIL_NUM_REGS
) (
  input  logic                ACLK,
  input  logic                ARSTn,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RVALID,
  input  logic                RREADY,
  output logic [ADDR_W-1:0]   rf_addr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic                rf_rw,
  input  logic [DATA_W-1:0]   rf_rdata
);

  localparam int STRB_W = DATA_W / 8;

  localparam logic [2:0] S_IDLE     = ST_IDLE;
  localparam logic [2:0] S_WR_EXEC  = ST_WR_EXEC;
  localparam logic [2:0] S_WR_RESP  = ST_WR_RESP;
  localparam logic [2:0] S_RD_ISSUE = ST_RD_ISSUE;
  localparam logic [2:0] S_RD_WAIT  = ST_RD_WAIT;
  localparam logic [2:0] S_RD_RESP  = ST_RD_RESP;

  logic [2:0]        r_state;
  logic              r_last_wr;   // 1 = last grant went to write, 0 = read
  logic              r_legal;     // legality of the transaction in flight
  logic              r_bvalid;
  logic [1:0]        r_bresp;
  logic              r_rvalid;
  logic [1:0]        r_rresp;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_rf_addr;
  logic [DATA_W-1:0] r_rf_wdata;
  logic              r_rf_rw;

  logic              w_idle;
  logic              w_wr_elig;
  logic              w_rd_elig;
  logic              w_wr_grant;
  logic              w_rd_grant;
  logic [ADDR_W-1:0] w_aw_idx;
  logic [ADDR_W-1:0] w_ar_idx;
  logic              w_wr_legal;
  logic              w_rd_legal;

  // Readies are never offered while reset is held so no handshake is lost.
  assign w_idle    = ARSTn && (r_state == S_IDLE);
  assign w_wr_elig = AWVALID && WVALID;
  assign w_rd_elig = ARVALID;

  assign w_aw_idx = {2'b00, AWADDR[ADDR_W-1:2]};
  assign w_ar_idx = {2'b00, ARADDR[ADDR_W-1:2]};

  // The package check covers the default map; the instance bound narrows it
  // further when fewer registers are built.
  assign w_wr_legal = addr_legal(AWADDR, WSTRB, 1'b1) &&
                      (w_aw_idx < ADDR_W'(NUM_REGS));
  assign w_rd_legal = addr_legal(ARADDR, {STRB_W{1'b0}}, 1'b0) &&
                      (w_ar_idx < ADDR_W'(NUM_REGS));

  // Grant arbitration: alternate between channels when both are eligible.
  always_comb begin
    w_wr_grant = 1'b0;
    w_rd_grant = 1'b0;
    if (w_idle) begin
      if (w_wr_elig && w_rd_elig) begin
        w_wr_grant = !r_last_wr;
        w_rd_grant = r_last_wr;
      end else begin
        w_wr_grant = w_wr_elig;
        w_rd_grant = w_rd_elig;
      end
    end else begin
      w_wr_grant = 1'b0;
      w_rd_grant = 1'b0;
    end
  end

  // Bridge FSM with the regfile strobe and the B/R response registers.
  always_ff @(posedge ACLK) begin
    if (!ARSTn) begin
      r_state    <= S_IDLE;
      r_last_wr  <= 1'b0;
      r_legal    <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_rvalid   <= 1'b0;
      r_rresp    <= RESP_OKAY;
      r_rdata    <= {DATA_W{1'b0}};
      r_rf_addr  <= {ADDR_W{1'b0}};
      r_rf_wdata <= {DATA_W{1'b0}};
      r_rf_rw    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_wr_grant) begin
            r_last_wr <= 1'b1;
            r_legal   <= w_wr_legal;
            r_rf_rw   <= w_wr_legal;
            // An illegal write leaves the regfile port untouched.
            if (w_wr_legal) begin
              r_rf_addr  <= w_aw_idx;
              r_rf_wdata <= WDATA;
            end
            r_state <= S_WR_EXEC;
          end else if (w_rd_grant) begin
            r_last_wr <= 1'b0;
            r_legal   <= w_rd_legal;
            if (w_rd_legal) begin
              r_rf_addr <= w_ar_idx;
            end
            r_state <= S_RD_ISSUE;
          end
        end
        S_WR_EXEC: begin
          r_rf_rw  <= 1'b0;
          r_bvalid <= 1'b1;
          r_bresp  <= r_legal ? RESP_OKAY : RESP_SLVERR;
          r_state  <= S_WR_RESP;
        end
        S_WR_RESP: begin
          if (BREADY) begin
            r_bvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        S_RD_ISSUE: begin
          // Regfile registers data_out on this edge.
          r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          r_rdata  <= r_legal ? rf_rdata : {DATA_W{1'b0}};
          r_rresp  <= r_legal ? RESP_OKAY : RESP_SLVERR;
          r_rvalid <= 1'b1;
          r_state  <= S_RD_RESP;
        end
        S_RD_RESP: begin
          if (RREADY) begin
            r_rvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: begin
          r_rf_rw  <= 1'b0;
          r_bvalid <= 1'b0;
          r_rvalid <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign AWREADY  = w_wr_grant;
  assign WREADY   = w_wr_grant;
  assign ARREADY  = w_rd_grant;
  assign BVALID   = r_bvalid;
  assign BRESP    = r_bresp;
  assign RVALID   = r_rvalid;
  assign RRESP    = r_rresp;
  assign RDATA    = r_rdata;
  assign rf_addr  = r_rf_addr;
  assign rf_wdata = r_rf_wdata;
  assign rf_rw    = r_rf_rw;

endmodule
